// File: rtl/mixcol_seq.sv
// -----------------------------------------------------------------------------
// mixcol_seq -- sequenced AES MixColumns engine for a 128-bit state.
//
// One 32-bit column is mixed per clock through a single shared column
// datapath built from mulby2 (GF(2^8) xtime) instances. A pass takes four
// RUN cycles, then done pulses for one cycle. The result stays on state_out
// until the next accepted start.
//
// Optional feature macro: MIXCOL_INV_EN
//   defined   -> an inv port exists; inv=1 selects InvMixColumns.
//                Each row byte gets a chain of three mulby2 stages.
//   undefined -> forward MixColumns only, one mulby2 per row byte.
//
// Ports:
//   clk        in   1    system clock, rising edge
//   rst_n      in   1    synchronous active-low reset
//   start      in   1    request a pass; honoured only in IDLE or DONE
//   inv        in   1    0 = forward, 1 = inverse (MIXCOL_INV_EN only)
//   state_in   in   128  input state; column c = [127-32c -: 32],
//                        row 0 byte in the column MSBs
//   state_out  out  128  working / result register, same byte order
//   busy       out  1    high while columns are being processed
//   done       out  1    one-cycle completion pulse
// -----------------------------------------------------------------------------

// GF(2^8) multiply-by-2 (xtime), AES reduction polynomial x^8+x^4+x^3+x+1.
module mulby2 (
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
endmodule

module mixcol_seq #(
  parameter int NCOL = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
`ifdef MIXCOL_INV_EN
  input  logic         inv,
`endif
  input  logic [127:0] state_in,
  output logic [127:0] state_out,
  output logic         busy,
  output logic         done
);

  localparam logic [1:0] LAST_COL = 2'(NCOL - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [127:0]  work_q, work_d;
`ifdef MIXCOL_INV_EN
  logic          inv_q, inv_d;
`endif

  logic          accept;
  logic [31:0]   col_sel;
  logic [31:0]   mixed;
  logic [7:0]    a   [0:3];
  logic [7:0]    x2  [0:3];
`ifdef MIXCOL_INV_EN
  logic [7:0]    x4  [0:3];
  logic [7:0]    x8  [0:3];
  logic [7:0]    m09 [0:3];
  logic [7:0]    m0b [0:3];
  logic [7:0]    m0d [0:3];
  logic [7:0]    m0e [0:3];
`endif

  // A start is only honoured when no pass is in flight.
  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // ---------------------------------------------------------------------------
  // Column select. Unused encodings fall back to column 0 so nothing
  // undefined can reach the datapath.
  // ---------------------------------------------------------------------------
  always_comb begin
    case (col_q)
      2'd1:    col_sel = work_q[95:64];
      2'd2:    col_sel = work_q[63:32];
      2'd3:    col_sel = work_q[31:0];
      default: col_sel = work_q[127:96];
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shared column datapath: per-row byte split and xtime chain.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_mul
      assign a[gi] = col_sel[31-8*gi -: 8];

      mulby2 u_x2 (.a(a[gi]), .y(x2[gi]));
`ifdef MIXCOL_INV_EN
      // x4 and x8 are formed by chaining further xtime stages.
      mulby2 u_x4 (.a(x2[gi]), .y(x4[gi]));
      mulby2 u_x8 (.a(x4[gi]), .y(x8[gi]));

      assign m09[gi] = x8[gi] ^ a[gi];
      assign m0b[gi] = x8[gi] ^ x2[gi] ^ a[gi];
      assign m0d[gi] = x8[gi] ^ x4[gi] ^ a[gi];
      assign m0e[gi] = x8[gi] ^ x4[gi] ^ x2[gi];
`endif
    end

    // Row r sees the coefficient row rotated by r: byte r+j gets coef[j].
    for (gi = 0; gi < 4; gi++) begin : g_row
      localparam int R1 = (gi + 1) % 4;
      localparam int R2 = (gi + 2) % 4;
      localparam int R3 = (gi + 3) % 4;

      logic [7:0] fwd_b;
      // 02*a_r ^ 03*a_{r+1} ^ a_{r+2} ^ a_{r+3}, with 03*x = 02*x ^ x
      assign fwd_b = x2[gi] ^ x2[R1] ^ a[R1] ^ a[R2] ^ a[R3];

`ifdef MIXCOL_INV_EN
      logic [7:0] inv_b;
      assign inv_b = m0e[gi] ^ m0b[R1] ^ m0d[R2] ^ m09[R3];
      assign mixed[31-8*gi -: 8] = inv_q ? inv_b : fwd_b;
`else
      assign mixed[31-8*gi -: 8] = fwd_b;
`endif
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (col_q == LAST_COL) state_d = S_DONE;
      end
      S_DONE: begin
        // A start in DONE chains straight into the next pass.
        state_d = start ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  assign state_out = work_q;

  // ---------------------------------------------------------------------------
  // Working register, column counter and latched mode
  // ---------------------------------------------------------------------------
  always_comb begin
    col_d  = col_q;
    work_d = work_q;
`ifdef MIXCOL_INV_EN
    inv_d  = inv_q;
`endif
    if (accept) begin
      work_d = state_in;
      col_d  = 2'd0;
`ifdef MIXCOL_INV_EN
      inv_d  = inv;
`endif
    end else if (state_q == S_RUN) begin
      // Only the selected column changes; the others are held.
      case (col_q)
        2'd1:    work_d[95:64]  = mixed;
        2'd2:    work_d[63:32]  = mixed;
        2'd3:    work_d[31:0]   = mixed;
        default: work_d[127:96] = mixed;
      endcase
      col_d = col_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q  <= 2'd0;
      work_q <= 128'h0;
`ifdef MIXCOL_INV_EN
      inv_q  <= 1'b0;
`endif
    end else begin
      col_q  <= col_d;
      work_q <= work_d;
`ifdef MIXCOL_INV_EN
      inv_q  <= inv_d;
`endif
    end
  end

endmodule

// File: tb/tb_mixcol_seq.sv
// -----------------------------------------------------------------------------
// tb_mixcol_seq -- self-checking bench for mixcol_seq.
// The driver issues passes and pushes the expected result into a queue.
// A separate monitor pops and compares whenever done is seen.
// Expected values are either known AES vectors or come from a reference
// model built on a generic GF(2^8) multiply and the MixColumns matrices.
// -----------------------------------------------------------------------------
module tb_mixcol_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
`ifdef MIXCOL_INV_EN
  logic         inv;
`endif
  logic [127:0] state_in;
  logic [127:0] state_out;
  logic         busy;
  logic         done;

  int vectors     = 0;
  int miscompares = 0;
  int op_count    = 0;
  logic [127:0] exp_q[$];

  always #5 clk = ~clk;

  mixcol_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
`ifdef MIXCOL_INV_EN
    .inv      (inv),
`endif
    .state_in (state_in),
    .state_out(state_out),
    .busy     (busy),
    .done     (done)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(logic [7:0] x, logic [7:0] y);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_state(logic [127:0] s, bit inv_bit);
    logic [7:0]   coef [4];
    logic [127:0] r = s;
    logic [7:0]   acc;
    if (inv_bit) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else         coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(coef[(k - row + 4) % 4], s[127-32*c-8*k -: 8]);
        r[127-32*c-8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic void check(string name, logic [127:0] act, logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endfunction

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", {127'b0, done}, 128'h0);
        end else begin
          logic [127:0] e;
          e = exp_q.pop_front();
          $display("done: state_out=%h expected=%h", state_out, e);
          check("result", state_out, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge: raise start for one cycle, optionally scoreboard it.
  task automatic issue(input logic [127:0] data, input logic [127:0] expected, input bit push);
    op_count++;
    $display("op %0d: start state_in=%h", op_count, data);
    start    = 1'b1;
    state_in = data;
    if (push) exp_q.push_back(expected);
    @(negedge clk);
    start    = 1'b0;
    state_in = {$urandom, $urandom, $urandom, $urandom};
`ifdef MIXCOL_INV_EN
    inv      = 1'($urandom);
`endif
  endtask

  // Entered at the negedge after start was sampled; returns at the done negedge.
  task automatic check_timing(input int glitch_k);
    for (int k = 0; k < 4; k++) begin
      check("busy_phase", {126'b0, busy, done}, 128'h2);
      if (k == glitch_k) begin
        start    = 1'b1;
        state_in = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done_phase", {126'b0, busy, done}, 128'h1);
  endtask

  // From the done negedge: check done falls and the result is held.
  task automatic finish_op(input logic [127:0] expected);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("idle_flags", {126'b0, busy, done}, 128'h0);
      check("held_result", state_out, expected);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] d, e;
    bit           inv_bit;

    rst_n    = 1'b0;
    start    = 1'b0;
    state_in = '0;
`ifdef MIXCOL_INV_EN
    inv      = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    check("reset_state_out", state_out, 128'h0);
    check("reset_flags", {126'b0, busy, done}, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Known-answer vectors
    e = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    issue(128'hdb135345_f20a225c_01010101_c6c6c6c6, e, 1);
    check_timing(-1);
    finish_op(e);

    e = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    issue(128'hd4d4d4d5_2d26314c_00000000_ffffffff, e, 1);
    check_timing(-1);
    finish_op(e);

`ifdef MIXCOL_INV_EN
    inv = 1'b1;
    e = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;
    issue(128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, e, 1);
    check_timing(-1);
    finish_op(e);
    inv = 1'b0;
`endif

    // start during RUN is ignored
    d = {$urandom, $urandom, $urandom, $urandom};
    e = mix_state(d, 1'b0);
    issue(d, e, 1);
    check_timing(1);
    finish_op(e);

    // start in the DONE cycle chains into a second pass
    d = {$urandom, $urandom, $urandom, $urandom};
    e = mix_state(d, 1'b0);
    issue(d, e, 1);
    check_timing(-1);
    issue({4{32'h01010101}}, {4{32'h01010101}}, 1);
    check_timing(-1);
    finish_op({4{32'h01010101}});

    // reset mid-RUN after two columns
    issue({$urandom, $urandom, $urandom, $urandom}, 128'h0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrun_reset_out", state_out, 128'h0);
    check("midrun_reset_flags", {126'b0, busy, done}, 128'h0);
    repeat (6) @(negedge clk);
    e = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    issue(128'hdb135345_f20a225c_01010101_c6c6c6c6, e, 1);
    check_timing(-1);
    finish_op(e);

    // randomized passes against the model
    for (int n = 0; n < 20; n++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      inv_bit = 1'b0;
`ifdef MIXCOL_INV_EN
      inv_bit = 1'($urandom);
      inv     = inv_bit;
`endif
      e = mix_state(d, inv_bit);
      issue(d, e, 1);
      check_timing(-1);
      finish_op(e);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 128'(exp_q.size()), 128'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, vectors=%0d", vectors);
    $fatal(1);
  end

endmodule
